// File: rtl/lcd_score_display.sv
// Purpose: drives a 16x2 HD44780 LCD (8-bit, write-only) with both pong scores on line 1 and a banner on line 2.
// Latency: power-up init takes T_POWERUP + 39 byte slots; a score refresh starts the cycle after IDLE sees the change.
// Backpressure: none; rst_lcd and score changes are latched and serviced once the current sequence finishes.
module lcd_score_display #(
    parameter int T_POWERUP = 1000000,
    parameter int T_EN      = 25,
    parameter int T_CMD     = 2500,
    parameter int T_CLR     = 100000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [2:0] score_p1,
    input  logic [2:0] score_p2,
    input  logic       rst_lcd,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       busy
);

    typedef enum logic [2:0] {PWR_WAIT, INIT, LINE1, LINE2, CLEAR, IDLE} state_t;

    localparam int TMAX = (T_POWERUP > T_EN + T_CLR) ? T_POWERUP : (T_EN + T_CLR);
    localparam int CW   = $clog2(TMAX + 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(T_EN);
    localparam logic [CW-1:0] CMD_END  = CW'(T_EN + T_CMD);
    localparam logic [CW-1:0] CLR_END  = CW'(T_EN + T_CLR);
    localparam logic [127:0]  LINE1_TPL = "P1:0        P2:0";
    localparam logic [127:0]  BANNER    = "   PONG - GP3   ";

    state_t        state, state_nx;
    logic [4:0]    idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          from_full, from_full_nx;
    logic          pend_clr, pend_clr_nx;
    logic [2:0]    shown_p1, shown_p1_nx;
    logic [2:0]    shown_p2, shown_p2_nx;

    logic [7:0]    byte_dat;
    logic          byte_rs;
    logic [4:0]    last_idx;
    logic [3:0]    pos;
    logic          in_seq;
    logic          slot_end;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= PWR_WAIT;
            idx       <= '0;
            cnt       <= '0;
            from_full <= 1'b0;
            pend_clr  <= 1'b0;
            shown_p1  <= '0;
            shown_p2  <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cnt       <= cnt_nx;
            from_full <= from_full_nx;
            pend_clr  <= pend_clr_nx;
            shown_p1  <= shown_p1_nx;
            shown_p2  <= shown_p2_nx;
        end
    end

    // Byte of the current slot; index 0 of LINE1/LINE2 is the DDRAM address command.
    assign pos = 4'(idx - 5'd1);

    always_comb begin
        byte_dat = 8'h00;
        byte_rs  = 1'b0;
        last_idx = 5'd0;
        case (state)
            INIT: begin
                last_idx = 5'd4;
                case (idx)
                    5'd0, 5'd1: byte_dat = 8'h38;
                    5'd2:       byte_dat = 8'h0C;
                    5'd3:       byte_dat = 8'h01;
                    default:    byte_dat = 8'h06;
                endcase
            end
            LINE1: begin
                last_idx = 5'd16;
                if (idx == 5'd0) begin
                    byte_dat = 8'h80;
                end else begin
                    byte_rs = 1'b1;
                    if (pos == 4'd3)
                        byte_dat = 8'h30 + {5'd0, shown_p1};
                    else if (pos == 4'd15)
                        byte_dat = 8'h30 + {5'd0, shown_p2};
                    else
                        byte_dat = LINE1_TPL[{4'd15 - pos, 3'd0} +: 8];
                end
            end
            LINE2: begin
                last_idx = 5'd16;
                if (idx == 5'd0) begin
                    byte_dat = 8'hC0;
                end else begin
                    byte_rs  = 1'b1;
                    byte_dat = BANNER[{4'd15 - pos, 3'd0} +: 8];
                end
            end
            CLEAR:   byte_dat = 8'h01;
            default: byte_dat = 8'h00;
        endcase
    end

    assign in_seq   = (state != PWR_WAIT) && (state != IDLE);
    assign slot_end = (cnt == ((!byte_rs && byte_dat == 8'h01) ? CLR_END : CMD_END));

    assign lcd_data = byte_dat;
    assign lcd_rs   = byte_rs;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = in_seq && (cnt != '0) && (cnt <= EN_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        cnt_nx       = cnt + 1'b1;
        from_full_nx = from_full;
        pend_clr_nx  = pend_clr;
        shown_p1_nx  = shown_p1;
        shown_p2_nx  = shown_p2;

        // Snapshot scores while the 0x80 command is being set up so a line never tears.
        if (state == LINE1 && idx == 5'd0 && cnt == '0) begin
            shown_p1_nx = score_p1;
            shown_p2_nx = score_p2;
        end

        case (state)
            PWR_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_nx = INIT;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            end
            IDLE: begin
                cnt_nx = '0;
                idx_nx = '0;
                if (pend_clr) begin
                    state_nx    = CLEAR;
                    pend_clr_nx = 1'b0;
                end else if (score_p1 != shown_p1 || score_p2 != shown_p2) begin
                    state_nx     = LINE1;
                    from_full_nx = 1'b0;
                end
            end
            default: begin
                if (slot_end) begin
                    cnt_nx = '0;
                    if (idx == last_idx) begin
                        idx_nx = '0;
                        case (state)
                            INIT, CLEAR: begin
                                state_nx     = LINE1;
                                from_full_nx = 1'b1;
                            end
                            LINE1:   state_nx = from_full ? LINE2 : IDLE;
                            default: state_nx = IDLE;
                        endcase
                    end else begin
                        idx_nx = idx + 5'd1;
                    end
                end
            end
        endcase

        // A request arriving in the same cycle IDLE consumes the old one still counts.
        if (rst_lcd && state != PWR_WAIT && state != INIT)
            pend_clr_nx = 1'b1;
    end

endmodule

// File: tb/tb_lcd_score_display.sv
// Bench for lcd_score_display: captures every strobed LCD byte and compares the stream, slot timing
// and strobe protocol against byte sequences built from the display's text layout.
module tb_lcd_score_display;

    localparam int T_POWERUP = 100;
    localparam int T_EN      = 4;
    localparam int T_CMD     = 10;
    localparam int T_CLR     = 40;
    localparam int SLOT      = 1 + T_EN + T_CMD;
    localparam int SLOT_CLR  = 1 + T_EN + T_CLR;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b1;
    logic [2:0] score_p1 = 3'd0;
    logic [2:0] score_p2 = 3'd0;
    logic       rst_lcd = 1'b0;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int run_id = 0;
    int rw_err = 0;
    int hold_err = 0;
    int en_err = 0;

    logic [8:0] cap[$];
    logic [8:0] exp_q[$];
    int         cap_cyc[$];
    int         cap_run[$];

    lcd_score_display #(
        .T_POWERUP(T_POWERUP), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .Clock(Clock), .Reset_n(Reset_n), .score_p1(score_p1), .score_p2(score_p2),
        .rst_lcd(rst_lcd), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(lcd_en), .busy(busy)
    );

    always #5 Clock = ~Clock;

    initial forever begin
        @(posedge Clock);
        cyc++;
    end

    // Byte capture and strobe protocol monitor, sampled on the falling clock edge.
    initial begin
        logic       en_q = 1'b0;
        logic       busy_q = 1'b1;
        logic [8:0] held = '0;
        int         en_w = 0;
        forever begin
            @(negedge Clock);
            if (lcd_rw !== 1'b0) rw_err++;
            if (lcd_en === 1'b1) begin
                if (!en_q) begin
                    held = {lcd_rs, lcd_data};
                    cap.push_back(held);
                    cap_cyc.push_back(cyc);
                    cap_run.push_back(run_id);
                    en_w = 1;
                end else begin
                    en_w++;
                    if ({lcd_rs, lcd_data} !== held) hold_err++;
                end
            end else if (en_q && Reset_n === 1'b1 && en_w != T_EN) begin
                en_err++;
            end
            if (busy_q && busy === 1'b0) run_id++;
            en_q   = (lcd_en === 1'b1);
            busy_q = (busy === 1'b1);
        end
    end

    // Reference byte streams built from the screen text.
    task automatic push_line1(input int p1, input int p2);
        string s;
        s = $sformatf("P1:%0d        P2:%0d", p1, p2);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[i]});
    endtask

    task automatic push_line2();
        string s;
        s = "   PONG - GP3   ";
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, s[i]});
    endtask

    task automatic push_init(input int p1, input int p2);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        push_line1(p1, p2);
        push_line2();
    endtask

    task automatic push_clear(input int p1, input int p2);
        exp_q.push_back(9'h001);
        push_line1(p1, p2);
        push_line2();
    endtask

    task automatic clear_cap();
        cap.delete();
        cap_cyc.delete();
        cap_run.delete();
        exp_q.delete();
    endtask

    function automatic int stream_diff();
        int n;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (cap[i] !== exp_q[i]) return i;
        return (cap.size() == exp_q.size()) ? -1 : n;
    endfunction

    function automatic string diff_msg(input int d);
        logic [8:0] g, w;
        g = (d < cap.size()) ? cap[d] : 9'h1FF;
        w = (d < exp_q.size()) ? exp_q[d] : 9'h1FF;
        return $sformatf("byte %0d got %h want %h (got %0d bytes, want %0d)", d, g, w, cap.size(), exp_q.size());
    endfunction

    // Slot length rule: 0x01 commands are followed by the long clear wait, all else by the short one.
    function automatic int spacing_bad();
        int bad = 0;
        for (int i = 1; i < cap.size(); i++)
            if (cap_run[i] == cap_run[i-1] &&
                cap_cyc[i] - cap_cyc[i-1] != ((cap[i-1] == 9'h001) ? SLOT_CLR : SLOT))
                bad++;
        return bad;
    endfunction

    task automatic wait_quiet(input int bound, output bit ok);
        int q = 0;
        for (int n = 0; n < bound && q < 20; n++) begin
            @(negedge Clock);
            if (busy === 1'b0) q++; else q = 0;
        end
        ok = (q >= 20);
    endtask

    task automatic wait_bytes(input int nb, input int bound, output bit ok);
        for (int n = 0; n < bound && cap.size() < nb; n++) @(negedge Clock);
        ok = (cap.size() >= nb);
    endtask

    task automatic new_scores(output logic [2:0] np1, output logic [2:0] np2);
        do begin
            np1 = 3'($urandom_range(7, 0));
            np2 = 3'($urandom_range(7, 0));
        end while (np1 == score_p1 && np2 == score_p2);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clock);
        tests++; if (lcd_en !== 1'b0)     begin fails++; $display("FAIL reset_en got %b want 0", lcd_en); end
        tests++; if (lcd_rs !== 1'b0)     begin fails++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
        tests++; if (lcd_rw !== 1'b0)     begin fails++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
        tests++; if (lcd_data !== 8'h00)  begin fails++; $display("FAIL reset_data got %h want 00", lcd_data); end
        tests++; if (busy !== 1'b1)       begin fails++; $display("FAIL reset_busy got %b want 1", busy); end
    endtask

    // Power-up; rst_lcd pulses during PWR_WAIT and INIT must not add a clear.
    task automatic test_init();
        bit ok;
        int fall, d;
        clear_cap();
        push_init(0, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        rel_cyc = cyc;
        for (int n = 0; n < 2000 && busy !== 1'b0; n++) begin
            @(negedge Clock);
            rst_lcd = (cyc - rel_cyc == 50) || (cyc - rel_cyc == 150);
        end
        rst_lcd = 1'b0;
        fall = (busy === 1'b0) ? cyc - rel_cyc : -1;
        tests++; if (fall != T_POWERUP + 38 * SLOT + SLOT_CLR) begin
            fails++; $display("FAIL init_busy_fall got %0d want %0d", fall, T_POWERUP + 38 * SLOT + SLOT_CLR);
        end
        wait_quiet(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL init_quiet got busy=%b want idle", busy); end
        d = (cap_cyc.size() > 0) ? cap_cyc[0] - rel_cyc : -1;
        tests++; if (d != T_POWERUP + 1) begin fails++; $display("FAIL init_first_en got %0d want %0d", d, T_POWERUP + 1); end
        d = stream_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL init_stream %s", diff_msg(d)); end
        d = spacing_bad();
        tests++; if (d != 0) begin fails++; $display("FAIL init_spacing got %0d bad slots want 0", d); end
    endtask

    // Score changes in IDLE rewrite only line 1; a 1-cycle glitch mid-line adds nothing.
    task automatic test_score();
        bit ok;
        int d;
        logic [2:0] np1, np2;
        for (int it = 0; it < 5; it++) begin
            clear_cap();
            if (it == 0) begin np1 = 3'd3; np2 = score_p2; end
            else new_scores(np1, np2);
            push_line1(np1, np2);
            @(negedge Clock);
            score_p1 = np1;
            score_p2 = np2;
            @(negedge Clock);
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL score_busy_rise it%0d got %b want 1", it, busy); end
            if (it == 4) begin
                wait_bytes(3, 200, ok);
                score_p2 = score_p2 + 3'd1;
                @(negedge Clock);
                score_p2 = np2;
            end
            wait_quiet(3000, ok);
            tests++; if (!ok) begin fails++; $display("FAIL score_quiet it%0d got busy=%b want idle", it, busy); end
            d = stream_diff();
            tests++; if (d != -1) begin fails++; $display("FAIL score_stream it%0d %s", it, diff_msg(d)); end
            d = spacing_bad();
            tests++; if (d != 0) begin fails++; $display("FAIL score_spacing it%0d got %0d want 0", it, d); end
        end
    endtask

    task automatic test_clear();
        bit ok;
        int d;
        clear_cap();
        push_clear(score_p1, score_p2);
        @(negedge Clock); rst_lcd = 1'b1;
        @(negedge Clock); rst_lcd = 1'b0;
        @(negedge Clock);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy_rise got %b want 1", busy); end
        wait_quiet(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL clear_quiet got busy=%b want idle", busy); end
        d = stream_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL clear_stream %s", diff_msg(d)); end
        d = spacing_bad();
        tests++; if (d != 0) begin fails++; $display("FAIL clear_spacing got %0d want 0", d); end
        // A second request during the clear sequence queues exactly one more.
        clear_cap();
        push_clear(score_p1, score_p2);
        push_clear(score_p1, score_p2);
        @(negedge Clock); rst_lcd = 1'b1;
        @(negedge Clock); rst_lcd = 1'b0;
        wait_bytes(5, 500, ok);
        rst_lcd = 1'b1;
        @(negedge Clock); rst_lcd = 1'b0;
        wait_quiet(5000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL clear2_quiet got busy=%b want idle", busy); end
        d = stream_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL clear2_stream %s", diff_msg(d)); end
        d = spacing_bad();
        tests++; if (d != 0) begin fails++; $display("FAIL clear2_spacing got %0d want 0", d); end
    endtask

    task automatic test_midchange();
        bit ok;
        int d;
        logic [2:0] np1;
        clear_cap();
        @(negedge Clock); score_p2 = 3'd2;
        wait_quiet(3000, ok);
        clear_cap();
        np1 = 3'(score_p1 + 3'($urandom_range(7, 1)));
        push_line1(np1, 2);
        push_line1(np1, 4);
        @(negedge Clock); score_p1 = np1;
        wait_bytes(3, 200, ok);
        score_p2 = 3'd4;
        wait_quiet(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL mid_quiet got busy=%b want idle", busy); end
        d = stream_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL mid_stream %s", diff_msg(d)); end
        d = spacing_bad();
        tests++; if (d != 0) begin fails++; $display("FAIL mid_spacing got %0d want 0", d); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fall, d;
        clear_cap();
        @(negedge Clock); rst_lcd = 1'b1;
        @(negedge Clock); rst_lcd = 1'b0;
        for (int n = 0; n < 200 && lcd_en !== 1'b1; n++) @(negedge Clock);
        tests++; if (lcd_en !== 1'b1) begin fails++; $display("FAIL rstmid_en_seen got %b want 1", lcd_en); end
        #2 Reset_n = 1'b0;
        #1;
        tests++; if (lcd_en !== 1'b0)    begin fails++; $display("FAIL rstmid_en got %b want 0", lcd_en); end
        tests++; if (lcd_rs !== 1'b0)    begin fails++; $display("FAIL rstmid_rs got %b want 0", lcd_rs); end
        tests++; if (lcd_data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", lcd_data); end
        tests++; if (busy !== 1'b1)      begin fails++; $display("FAIL rstmid_busy got %b want 1", busy); end
        repeat (3) @(negedge Clock);
        clear_cap();
        push_init(score_p1, score_p2);
        Reset_n = 1'b1;
        rel_cyc = cyc;
        for (int n = 0; n < 2000 && busy !== 1'b0; n++) @(negedge Clock);
        fall = (busy === 1'b0) ? cyc - rel_cyc : -1;
        tests++; if (fall != T_POWERUP + 38 * SLOT + SLOT_CLR) begin
            fails++; $display("FAIL rstmid_busy_fall got %0d want %0d", fall, T_POWERUP + 38 * SLOT + SLOT_CLR);
        end
        wait_quiet(3000, ok);
        d = (cap_cyc.size() > 0) ? cap_cyc[0] - rel_cyc : -1;
        tests++; if (d != T_POWERUP + 1) begin fails++; $display("FAIL rstmid_first_en got %0d want %0d", d, T_POWERUP + 1); end
        d = stream_diff();
        tests++; if (d != -1) begin fails++; $display("FAIL rstmid_stream %s", diff_msg(d)); end
    endtask

    task automatic test_protocol();
        tests++; if (rw_err != 0)   begin fails++; $display("FAIL proto_rw got %0d cycles with rw!=0 want 0", rw_err); end
        tests++; if (hold_err != 0) begin fails++; $display("FAIL proto_hold got %0d changes under en want 0", hold_err); end
        tests++; if (en_err != 0)   begin fails++; $display("FAIL proto_en_width got %0d bad strobes want 0", en_err); end
    endtask

    initial begin
        #1;
        test_reset();
        test_init();
        test_score();
        test_clear();
        test_midchange();
        test_reset_mid();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
